// File: rtl/cdb_arbiter.sv
// cdb_arbiter - common data bus arbiter for a Tomasulo-style back end.
//
// Picks at most one functional-unit requester per cycle with a round-robin
// pointer. It registers the winner's tag and value onto the broadcast bus one
// cycle later.
//
// Optional feature macro: CDB_LOAD_PRIORITY_EN
//   When this macro is defined, requester 0 (the load station) always wins if
//   it is eligible, and it does not advance the pointer. Requesters 1..3
//   round-robin among themselves.
//   When it is undefined, all four requesters share one round-robin.
//
// Ports
//   clk       : single clock; state changes on the rising edge
//   rst       : synchronous active-high reset
//   req       : per-requester "result ready"
//   reqLabel  : packed producer tags, requester i at [i*LW +: LW]
//   reqData   : packed result values, requester i at [i*DW +: DW]
//   cdbStall  : suppresses any grant this cycle
//   grant     : combinational one-hot grant, valid in the request cycle
//   BCEN      : registered broadcast enable
//   BClabel   : registered broadcast tag (0 when idle)
//   BCdata    : registered broadcast value (0 when idle)
//   protoErr  : sticky flag; set when a request carries label 0
module cdb_arbiter #(
  parameter int NREQ = 4,
  parameter int LW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LW-1:0]   reqLabel,
  input  logic [NREQ*DW-1:0]   reqData,
  input  logic                 cdbStall,
  output logic [NREQ-1:0]      grant,
  output logic                 BCEN,
  output logic [LW-1:0]        BClabel,
  output logic [DW-1:0]        BCdata,
  output logic                 protoErr
);

  logic [1:0]      r_ptr;
  logic            r_bcen;
  logic [LW-1:0]   r_bclabel;
  logic [DW-1:0]   r_bcdata;
  logic            r_proto_err;

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_bad;
  logic            w_found;
  logic [1:0]      w_sel;
  logic [1:0]      w_start;
  logic            w_fire;
  logic            w_ptr_upd;
  logic [LW-1:0]   w_label;
  logic [DW-1:0]   w_data;

  // A label of 0 means "no tag". Such a request is never granted, and it is
  // flagged as a protocol violation.
  always_comb begin
    w_elig = '0;
    w_bad  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req[i] && (reqLabel[i*LW +: LW] != '0);
      w_bad[i]  = req[i] && (reqLabel[i*LW +: LW] == '0);
    end
  end

`ifdef CDB_LOAD_PRIORITY_EN
  // Rotating index over requesters 1..3 only.
  function automatic logic [1:0] rr3_idx(input logic [1:0] start, input logic [1:0] k);
    logic [2:0] sum;
    sum = {1'b0, start} + {1'b0, k};
    if (sum > 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  // The pointer wraps to 0 after a grant to requester 3. In this mode, a
  // pointer of 0 means "start the search at requester 1".
  always_comb begin
    w_found = 1'b0;
    w_sel   = 2'd0;
    w_start = (r_ptr == 2'd0) ? 2'd1 : r_ptr;
    if (w_elig[0]) begin
      w_found = 1'b1;
      w_sel   = 2'd0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!w_found && w_elig[rr3_idx(w_start, 2'(k))]) begin
          w_found = 1'b1;
          w_sel   = rr3_idx(w_start, 2'(k));
        end
      end
    end
  end

  assign w_ptr_upd = w_fire && (w_sel != 2'd0);
`else
  // First eligible requester at or after the pointer. The 2-bit index sum
  // wraps from 3 to 0 on its own.
  always_comb begin
    w_found = 1'b0;
    w_sel   = 2'd0;
    w_start = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_elig[w_start + 2'(k)]) begin
        w_found = 1'b1;
        w_sel   = w_start + 2'(k);
      end
    end
  end

  assign w_ptr_upd = w_fire;
`endif

  // Gating the grant with rst keeps it at zero in every reset cycle.
  assign w_fire = w_found && !cdbStall && !rst;

  always_comb begin
    grant   = '0;
    w_label = '0;
    w_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_fire && (w_sel == 2'(i))) begin
        grant[i] = 1'b1;
        w_label  = reqLabel[i*LW +: LW];
        w_data   = reqData[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= 2'd0;
      r_bcen      <= 1'b0;
      r_bclabel   <= '0;
      r_bcdata    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_bcen    <= w_fire;
      r_bclabel <= w_label;
      r_bcdata  <= w_data;
      if (w_ptr_upd) r_ptr <= w_sel + 2'd1;
      if (|w_bad)    r_proto_err <= 1'b1;
    end
  end

  assign BCEN     = r_bcen;
  assign BClabel  = r_bclabel;
  assign BCdata   = r_bcdata;
  assign protoErr = r_proto_err;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter - directed scenarios followed by randomized traffic.
// Every cycle is checked against a behavioural arbiter model.
module tb_cdb_arbiter;

  localparam int NREQ = 4;
  localparam int LW   = 5;
  localparam int DW   = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*LW-1:0]   reqLabel;
  logic [NREQ*DW-1:0]   reqData;
  logic                 cdbStall;
  logic [NREQ-1:0]      grant;
  logic                 BCEN;
  logic [LW-1:0]        BClabel;
  logic [DW-1:0]        BCdata;
  logic                 protoErr;

  cdb_arbiter #(.NREQ(NREQ), .LW(LW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .reqLabel (reqLabel),
    .reqData  (reqData),
    .cdbStall (cdbStall),
    .grant    (grant),
    .BCEN     (BCEN),
    .BClabel  (BClabel),
    .BCdata   (BCdata),
    .protoErr (protoErr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state. m_ptr is the requester the next search starts from. In
  // priority mode it only takes the values 1..3 once requester 1..3 is served.
  int m_ptr = 0;
  bit m_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit elig(input int i);
    return req[i] && (reqLabel[i*LW +: LW] != 0);
  endfunction

  // The winner is the eligible requester closest to the pointer, counting
  // upward with wrap-around.
  function automatic int model_pick();
    int best;
    int bestd;
    int d;
    int s;
    best  = -1;
    bestd = 99;
    if (rst || cdbStall) return -1;
`ifdef CDB_LOAD_PRIORITY_EN
    if (elig(0)) return 0;
    s = (m_ptr == 0) ? 1 : m_ptr;
    for (int i = 1; i < 4; i++) begin
      d = (i - s + 3) % 3;
      if (elig(i) && d < bestd) begin best = i; bestd = d; end
    end
`else
    s = m_ptr;
    for (int i = 0; i < 4; i++) begin
      d = (i - s + 4) % 4;
      if (elig(i) && d < bestd) begin best = i; bestd = d; end
    end
`endif
    return best;
  endfunction

  // Check one cycle: the grant before the edge, then the registered outputs
  // after it.
  task automatic step(output int g);
    logic [LW-1:0] el;
    logic [DW-1:0] ed;
    logic [63:0]   eg;
    bit            bad;
    bit            was_rst;
    #1;
    g  = model_pick();
    eg = (g < 0) ? 64'd0 : (64'd1 << g);
    check("grant", {60'd0, grant}, eg);
    el = '0;
    ed = '0;
    if (g >= 0) begin
      el = reqLabel[g*LW +: LW];
      ed = reqData[g*DW +: DW];
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++)
      if (req[i] && reqLabel[i*LW +: LW] == 0) bad = 1'b1;
    was_rst = rst;
    @(posedge clk);
    #1;
    if (was_rst) begin
      m_ptr = 0;
      m_err = 1'b0;
    end else begin
      if (bad) m_err = 1'b1;
`ifdef CDB_LOAD_PRIORITY_EN
      if (g > 0) m_ptr = (g == 3) ? 1 : g + 1;
`else
      if (g >= 0) m_ptr = (g + 1) % 4;
`endif
    end
    check("bcen",     {63'd0, BCEN},     {63'd0, (g >= 0)});
    check("bclabel",  {59'd0, BClabel},  {59'd0, el});
    check("bcdata",   {32'd0, BCdata},   {32'd0, ed});
    check("protoerr", {63'd0, protoErr}, {63'd0, m_err});
  endtask

  task automatic set_lane(input int i, input logic [LW-1:0] l, input logic [DW-1:0] d);
    reqLabel[i*LW +: LW] = l;
    reqData[i*DW +: DW]  = d;
  endtask

  task automatic clear_inputs();
    req      = '0;
    reqLabel = '0;
    reqData  = '0;
    cdbStall = 1'b0;
  endtask

  task automatic do_reset();
    int g;
    rst = 1'b1;
    clear_inputs();
    step(g);
    step(g);
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int seq [5];
    rst = 1'b1;
    clear_inputs();

    do_reset();
    check("rst_bcen", {63'd0, BCEN}, 64'd0);
    check("rst_perr", {63'd0, protoErr}, 64'd0);

    // One requester wins in the same cycle and broadcasts one cycle later.
    req = 4'b0001;
    set_lane(0, 5'd2, 32'd32);
    step(g);
    check("r28_grant", 64'(g), 64'd0);
    check("r28_label", {59'd0, BClabel}, 64'd2);
    check("r28_data",  {32'd0, BCdata}, 64'd32);
    clear_inputs();
    step(g);

    // All four requesters active with labels 1..4.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_lane(i, 5'(i + 1), 32'(100 + i));
    seq = '{1, 2, 3, 4, 1};
    for (int k = 0; k < 5; k++) begin
      step(g);
`ifndef CDB_LOAD_PRIORITY_EN
      check("r29_label", {59'd0, BClabel}, 64'(seq[k]));
`endif
    end
    clear_inputs();

    // Pointer wrap: drive it to 3, then serve requester 3 and then requester 0.
    req = 4'b0100; set_lane(2, 5'd7, 32'h77);
    step(g);
    clear_inputs();
    req = 4'b1000; set_lane(3, 5'd9, 32'h99);
    step(g);
    check("r30_g3", 64'(g), 64'd3);
    clear_inputs();
    req = 4'b0001; set_lane(0, 5'd5, 32'h55);
    step(g);
    check("r30_g0", 64'(g), 64'd0);
    clear_inputs();

    // A stall blocks all grants. After release, requester 1 wins first.
    req = 4'b0110; set_lane(1, 5'd10, 32'hA); set_lane(2, 5'd11, 32'hB);
    cdbStall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(g);
      check("r31_stall_bcen", {63'd0, BCEN}, 64'd0);
    end
    cdbStall = 1'b0;
    step(g);
    check("r31_first", 64'(g), 64'd1);
    clear_inputs();

    // A request with label 0 is ignored, and protoErr stays set until reset.
    req = 4'b0100; set_lane(2, 5'd0, 32'hDEAD);
    step(g);
    check("r32_perr", {63'd0, protoErr}, 64'd1);
    clear_inputs();
    for (int k = 0; k < 3; k++) step(g);
    check("r32_held", {63'd0, protoErr}, 64'd1);
    do_reset();
    check("r32_clr", {63'd0, protoErr}, 64'd0);

`ifdef CDB_LOAD_PRIORITY_EN
    // The load station dominates while it is eligible. The others rotate after it drops.
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_lane(i, 5'(i + 1), 32'(200 + i));
    for (int k = 0; k < 3; k++) begin
      step(g);
      check("r33_load", 64'(g), 64'd0);
    end
    req = 4'b1110;
    for (int k = 1; k < 4; k++) begin
      step(g);
      check("r33_rr", 64'(g), 64'(k));
    end
    clear_inputs();
`endif

    // Randomized traffic. Inputs are sometimes held and resets are occasional.
    for (int c = 0; c < 1500; c++) begin
      rst      = ($urandom_range(0, 99) < 3);
      cdbStall = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 3) != 0) begin
        req = 4'($urandom);
        for (int i = 0; i < 4; i++)
          set_lane(i, ($urandom_range(0, 24) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      end
      step(g);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of functional-unit requesters (load station, ALU stations, ...); fixed at 4 in this release.
REQ-002 The block SHALL have parameter LW, default 5, meaning the tag/label width.
REQ-003 The block SHALL have parameter DW, default 32, meaning the broadcast data width.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port req, input, NREQ, meaning that requester i has a result ready to broadcast.
REQ-007 The block SHALL have port reqLabel, input, NREQ*LW, meaning the packed producer tags, with requester i at bits [i*LW +: LW].
REQ-008 The block SHALL have port reqData, input, NREQ*DW, meaning the packed result values, with requester i at bits [i*DW +: DW].
REQ-009 The block SHALL have port cdbStall, input, 1, meaning that no grant is issued this cycle.
REQ-010 The block SHALL have port grant, output, NREQ, meaning a combinational one-hot grant in the request cycle.
REQ-011 The block SHALL have port BCEN, output, 1, meaning the registered broadcast enable.
REQ-012 The block SHALL have port BClabel, output, LW, meaning the registered broadcast tag.
REQ-013 The block SHALL have port BCdata, output, DW, meaning the registered broadcast value.
REQ-014 The block SHALL have port protoErr, output, 1, meaning a sticky protocol-violation flag.

Function
REQ-015 The block SHALL treat requester i as eligible in cycle t iff req[i]=1 and its label is nonzero (label 0 means "no tag").
REQ-016 The block SHALL assert at most one grant bit per cycle, and none when cdbStall=1 or no requester is eligible.
REQ-017 The block SHALL select, among eligible requesters, the first at or after round-robin pointer ptr (2 bits), searching upward with wrap-around from 3 to 0.
REQ-018 On a grant to i, ptr SHALL become (i+1) mod 4 at the next edge; with no grant, ptr SHALL hold.
REQ-019 On a grant to i in cycle t, at edge t+1: BCEN=1, BClabel=reqLabel[i], BCdata=reqData[i]; latency is exactly 1 cycle.
REQ-020 With no grant in cycle t, at edge t+1: BCEN=0, BClabel=0, BCdata=0.
REQ-021 Requesters SHALL hold req, label and data stable until granted, and drop or replace them in the cycle after the grant; the arbiter holds no copy beyond the output register.
REQ-022 A continuously eligible requester SHALL be granted within NREQ non-stalled cycles.
REQ-023 If req[i]=1 with label 0, the block SHALL ignore that request and set protoErr=1 at the next edge; protoErr SHALL stay set until reset.

Reset
REQ-024 While rst=1 at a rising edge: ptr=0, BCEN=0, BClabel=0, BCdata=0, protoErr=0; grant SHALL be 0 in every cycle rst=1.
REQ-025 A reset asserted on the edge that would register a broadcast SHALL win; that broadcast is lost, and the requester, still holding req, is re-arbitrated after reset.

Configuration
REQ-026 When CDB_LOAD_PRIORITY_EN is defined, requester 0 (load station) SHALL win whenever eligible, without updating ptr, and requesters 1..3 SHALL round-robin among themselves when requester 0 is not eligible.
REQ-027 When CDB_LOAD_PRIORITY_EN is undefined, all four requesters SHALL share a single round-robin per REQ-017/018; REQ-022 applies only in this mode.

Verification
REQ-028 The bench SHALL cover: reset, then req=0001, label0=2, data0=32 -> grant=0001 same cycle; next cycle BCEN=1, BClabel=2, BCdata=32; ptr=1.
REQ-029 The bench SHALL cover: all four requesting continuously with labels 1,2,3,4 from ptr=0 -> broadcast labels 1,2,3,4,1 on consecutive cycles.
REQ-030 The bench SHALL cover: req=1000 with ptr=3, then req=0001 -> grants 1000 then 0001, ptr wraps 3->0->1.
REQ-031 The bench SHALL cover: cdbStall=1 with req=0110 for 3 cycles -> grant=0 and BCEN=0 each cycle; on release, requester 1 is granted first.
REQ-032 The bench SHALL cover: req=0100 with label2=0 -> no grant, BCEN=0, protoErr=1 next cycle and held until rst.
REQ-033 The bench SHALL cover: with CDB_LOAD_PRIORITY_EN defined, req0 held high alongside req=1110 -> requester 0 granted every cycle; after req0 drops, requesters 1,2,3 are granted in order.
